// File: rtl/core_mem_port.sv
// core_mem_port: core-side initiator for one slot of the time-multiplexed shared-memory controller
module core_mem_port #(
  parameter int CORE_ID   = 0,
  parameter int NUM_CORES = 8,
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 16
) (
  input  logic              clk16,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] addr_o,
  output logic              we_o,
  output logic [DATA_W-1:0] dataIN_o,
  input  logic [DATA_W-1:0] dataOUT_i
);
  localparam int SW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_SLOT = 2'd1;
  localparam logic [1:0] WAIT_DATA = 2'd2;
  localparam logic [SW-1:0] MY_SLOT = SW'(CORE_ID);
  localparam logic [SW:0]   ROUND   = (SW+1)'(NUM_CORES);
  logic [1:0]        state_q, state_d;
  logic [SW-1:0]     slot_q;
  logic [SW:0]       rnd_q, rnd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              slot_edge;
  assign slot_edge = slot_q == MY_SLOT;
  assign req_ready = state_q == IDLE;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign addr_o    = addr_q;
  assign we_o      = we_q;
  assign dataIN_o  = din_q;
  // Next state: latch the request, wait for our slot, then ack the write or count a round for read data
  always_comb begin
    state_d     = state_q;
    rnd_d       = rnd_q;
    addr_d      = addr_q;
    we_d        = we_q;
    din_d       = din_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    if (state_q == IDLE) begin
      if (req_valid) begin
        state_d = WAIT_SLOT;
        addr_d  = req_addr;
        we_d    = req_we;
        din_d   = req_we ? req_wdata : '0;
      end
    end else if (state_q == WAIT_SLOT) begin
      if (slot_edge) begin
        state_d     = we_q ? IDLE : WAIT_DATA;
        rnd_d       = ROUND;
        we_d        = 1'b0;
        rsp_valid_d = we_q;
      end
    end else if (state_q == WAIT_DATA) begin
      rnd_d = rnd_q - 1'b1;
      if (rnd_q == '0) begin
        state_d     = IDLE;
        rsp_valid_d = 1'b1;
        rdata_d     = dataOUT_i;
      end
    end else begin
      state_d = IDLE;
    end
  end
  // State registers; the slot counter free-runs in lockstep with the controller round
  always_ff @(posedge clk16) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      slot_q      <= '0;
      rnd_q       <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      din_q       <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_q + 1'b1;
      rnd_q       <= rnd_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      din_q       <= din_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
    end
  end
endmodule

// File: tb/tb_core_mem_port.sv
// tb_core_mem_port: randomized check of three slot initiators against a shared-memory controller model
module tb_core_mem_port;
  logic        clk16 = 1'b0;
  logic        rst_n;
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_we    [3];
  logic [11:0] req_addr  [3];
  logic [15:0] req_wdata [3];
  logic        rsp_valid [3];
  logic [15:0] rsp_rdata [3];
  logic [11:0] addr_o    [3];
  logic        we_o      [3];
  logic [15:0] dataIN_o  [3];
  logic [15:0] dout      [3];
  logic [11:0] rd_addr   [3];
  logic [15:0] mem       [3][4096];
  int          wr_cnt    [3];
  int          wr_edge   [3];
  logic [15:0] shadow    [3][4096];
  bit          written   [3][4096];
  int          edges  = 0;
  int          slot_m = 0;
  int          checks = 0;
  int          errors = 0;
  always #5 clk16 = ~clk16;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    core_mem_port #(.CORE_ID(g == 0 ? 3 : g == 1 ? 0 : 7), .NUM_CORES(8), .ADDR_W(12), .DATA_W(16)) u_dut (
      .clk16(clk16), .rst_n(rst_n),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_we(req_we[g]),
      .req_addr(req_addr[g]), .req_wdata(req_wdata[g]),
      .rsp_valid(rsp_valid[g]), .rsp_rdata(rsp_rdata[g]),
      .addr_o(addr_o[g]), .we_o(we_o[g]), .dataIN_o(dataIN_o[g]), .dataOUT_i(dout[g])
    );
  end
  function automatic int cid(input int k);
    return k == 0 ? 3 : k == 1 ? 0 : 7;
  endfunction
  // Controller model: each core is sampled only at its slot edge; read data appears one round later
  always @(posedge clk16) begin
    edges  <= edges + 1;
    slot_m <= rst_n ? (slot_m + 1) % 8 : 0;
    for (int k = 0; k < 3; k++) begin
      if (slot_m == cid(k)) begin
        if (we_o[k]) begin
          mem[k][addr_o[k]] <= dataIN_o[k];
          wr_cnt[k]  <= wr_cnt[k] + 1;
          wr_edge[k] <= edges + 1;
        end
        dout[k]    <= mem[k][rd_addr[k]];
        rd_addr[k] <= addr_o[k];
      end
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at edge %0d", tag, got, exp, edges);
    end
  endtask
  task automatic align(input int s);
    int n = 0;
    while (slot_m != s && n < 16) begin
      @(negedge clk16);
      n++;
    end
    check("align", slot_m, s);
  endtask
  task automatic issue(input int k, input bit we, input logic [11:0] a, input logic [15:0] d, output int iss);
    int n = 0;
    int w;
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_addr[k]  = a;
    req_wdata[k] = d;
    while (!req_ready[k] && n < 32) begin
      @(negedge clk16);
      n++;
    end
    check("ready_wait", req_ready[k], 1);
    w = (cid(k) + 8 - slot_m) % 8;
    iss = edges + 1 + (w == 0 ? 8 : w);
    @(negedge clk16);
  endtask
  task automatic txn(input int k, input bit we, input logic [11:0] a, input logic [15:0] d, input bit hold);
    int iss, fin, wc;
    wc = wr_cnt[k];
    issue(k, we, a, d, iss);
    fin = we ? iss : iss + 9;
    req_valid[k] = hold;
    req_we[k]    = 1'($urandom);
    req_addr[k]  = 12'($urandom);
    req_wdata[k] = 16'($urandom);
    while (edges < fin) begin
      check("busy_rsp", rsp_valid[k], 0);
      check("busy_ready", req_ready[k], 0);
      check("busy_addr", addr_o[k], a);
      check("busy_we", we_o[k], (we && edges < iss) ? 1 : 0);
      @(negedge clk16);
    end
    check("rsp_valid", rsp_valid[k], 1);
    check("rsp_ready", req_ready[k], 1);
    check("rsp_we", we_o[k], 0);
    check("wr_count", wr_cnt[k] - wc, we ? 1 : 0);
    if (we) begin
      check("wr_edge", wr_edge[k], iss);
      check("wr_mem", mem[k][a], d);
      shadow[k][a]  = d;
      written[k][a] = 1'b1;
    end else begin
      check("rdata", rsp_rdata[k], shadow[k][a]);
    end
  endtask
  task automatic idle(input int k, input int n);
    repeat (n) begin
      @(negedge clk16);
      check("idle_rsp", rsp_valid[k], 0);
      check("idle_ready", req_ready[k], 1);
      check("idle_we", we_o[k], 0);
    end
  endtask
  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk16);
    rst_n = 1'b1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [11:0] pool [8];
    int iss, wc, k;
    bit we;
    logic [11:0] a;
    pool = '{12'h000, 12'hFFF, 12'h010, 12'h123, 12'h200, 12'h7FF, 12'h800, 12'h555};
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = '0; req_wdata[i] = '0;
      wr_cnt[i] = 0; wr_edge[i] = 0;
    end
    repeat (3) @(negedge clk16);
    for (int i = 0; i < 3; i++) begin
      check("rst_ready", req_ready[i], 1);
      check("rst_rsp", rsp_valid[i], 0);
      check("rst_rdata", rsp_rdata[i], 0);
      check("rst_addr", addr_o[i], 0);
      check("rst_we", we_o[i], 0);
      check("rst_din", dataIN_o[i], 0);
    end
    rst_n = 1'b1;
    align(5);
    txn(0, 1'b1, 12'h010, 16'h0ABC, 1'b0);
    idle(0, 2);
    txn(0, 1'b0, 12'h010, 16'h0000, 1'b0);
    idle(0, 1);
    align(3);
    txn(0, 1'b1, 12'h123, 16'h1357, 1'b0);
    align(3);
    txn(0, 1'b0, 12'h123, 16'h0000, 1'b0);
    idle(0, 1);
    txn(0, 1'b1, 12'h200, 16'hBEEF, 1'b1);
    txn(0, 1'b0, 12'h200, 16'h0000, 1'b0);
    idle(0, 1);
    issue(0, 1'b0, 12'h010, 16'h0000, iss);
    req_valid[0] = 1'b0;
    while (edges < iss + 3) @(negedge clk16);
    pulse_reset();
    check("rst_slot", slot_m, 0);
    idle(0, 12);
    txn(0, 1'b0, 12'h010, 16'h0000, 1'b0);
    idle(0, 1);
    align(4);
    wc = wr_cnt[0];
    issue(0, 1'b1, 12'h010, 16'h5555, iss);
    req_valid[0] = 1'b0;
    @(negedge clk16);
    pulse_reset();
    idle(0, 12);
    check("rst_no_write", wr_cnt[0] - wc, 0);
    check("rst_mem", mem[0][12'h010], 16'h0ABC);
    txn(0, 1'b0, 12'h010, 16'h0000, 1'b0);
    idle(0, 1);
    for (int i = 1; i < 3; i++) begin
      txn(i, 1'b1, 12'h000, 16'($urandom), 1'b0);
      idle(i, 1);
      txn(i, 1'b1, 12'hFFF, 16'($urandom), 1'b0);
      idle(i, 1);
      txn(i, 1'b0, 12'h000, 16'h0000, 1'b1);
      txn(i, 1'b0, 12'hFFF, 16'h0000, 1'b0);
      idle(i, 1);
    end
    for (int n = 0; n < 40; n++) begin
      k  = $urandom_range(0, 2);
      a  = pool[$urandom_range(0, 7)];
      we = written[k][a] ? 1'($urandom) : 1'b1;
      txn(k, we, a, 16'($urandom), 1'b0);
      idle(k, $urandom_range(1, 4));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
